// File: rtl/demux_pkg.sv
// demux_pkg: shared destination count and index type for the mux/demux blocks
package demux_pkg;
  localparam int N_OUT = 4;
  typedef logic [1:0] dest_t;
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output buffer with load/drain handshake
module demux_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (load) dout <= din;
      valid <= load | (valid & ~ready);
    end
endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes a valid/ready stream to one of four buffered outputs
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
);
  logic [N_OUT-1:0] load;
  logic [WIDTH-1:0] y [N_OUT];
  // a full slot still accepts when it is draining in the same cycle
  assign d_ready = ~y_valid[sel] | y_ready[sel];
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign load[i] = d_valid & d_ready & (sel == dest_t'(i));
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .din   (d),
      .ready (y_ready[i]),
      .valid (y_valid[i]),
      .dout  (y[i])
    );
  end
  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: queue-model checker plus directed and random stimulus
`timescale 1ns/1ps
module tb_demux_1_4_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d = '0;
  logic [1:0] sel = '0;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic [3:0] y_ready = '0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] q [4][$];
  logic [3:0] last [4];

  demux_1_4_stream #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .d_valid(d_valid), .d_ready(d_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] dd, input logic [3:0] yr);
    @(posedge clk);
    #1;
    d_valid = v;
    sel = s;
    d = dd;
    y_ready = yr;
  endtask

  // model: each destination is a FIFO of capacity one; outputs follow from its contents
  always @(negedge clk) begin
    logic [3:0] ys [4];
    logic [3:0] ev;
    logic       er;
    ys = '{y0, y1, y2, y3};
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        last[i] = '0;
        chk($sformatf("rst_y%0d", i), ys[i], 0);
      end
      chk("rst_y_valid", y_valid, 0);
    end else begin
      for (int i = 0; i < 4; i++) ev[i] = q[i].size() > 0;
      er = (q[sel].size() == 0) || y_ready[sel];
      chk("y_valid", y_valid, ev);
      chk("d_ready", d_ready, er);
      for (int i = 0; i < 4; i++)
        chk($sformatf("y%0d", i), ys[i], ev[i] ? q[i][0] : last[i]);
      for (int i = 0; i < 4; i++)
        if (ev[i] && y_ready[i]) void'(q[i].pop_front());
      if (d_valid && er) begin
        q[sel].push_back(d);
        last[sel] = d;
      end
    end
  end

  initial begin
    logic hold;
    int left;
    repeat (2) @(posedge clk);
    #3;
    chk("lit_reset_valid", y_valid, 4'b0000);
    chk("lit_reset_ready", d_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // routing, all consumers ready
    drive(1, 0, 4'hA, 4'hF); #2 chk("lit_route_ready", d_ready, 1);
    drive(1, 1, 4'hB, 4'hF); #2 chk("lit_route_v0", y_valid, 4'b0001); chk("lit_route_y0", y0, 4'hA);
    drive(1, 2, 4'hC, 4'hF); #2 chk("lit_route_v1", y_valid, 4'b0010); chk("lit_route_y1", y1, 4'hB);
    drive(1, 3, 4'hD, 4'hF); #2 chk("lit_route_v2", y_valid, 4'b0100); chk("lit_route_y2", y2, 4'hC);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_route_v3", y_valid, 4'b1000); chk("lit_route_y3", y3, 4'hD);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_route_idle", y_valid, 4'b0000); chk("lit_route_hold", y3, 4'hD);
    // backpressure on slot 2
    drive(1, 2, 4'h5, 4'b1011); #2 chk("lit_bp_ready1", d_ready, 1);
    drive(1, 2, 4'h6, 4'b1011); #2 chk("lit_bp_v", y_valid, 4'b0100); chk("lit_bp_y2", y2, 4'h5); chk("lit_bp_stall", d_ready, 0);
    drive(1, 2, 4'h6, 4'b1011); #2 chk("lit_bp_y2_hold", y2, 4'h5); chk("lit_bp_stall2", d_ready, 0);
    drive(1, 2, 4'h6, 4'b1111); #2 chk("lit_bp_release", d_ready, 1);
    drive(0, 0, 4'h0, 4'b1011); #2 chk("lit_bp_y2_new", y2, 4'h6); chk("lit_bp_v2", y_valid, 4'b0100);
    // bypass while slot 2 is stalled
    drive(1, 0, 4'h7, 4'b1011); #2 chk("lit_byp_ready", d_ready, 1);
    drive(0, 0, 4'h0, 4'b1011); #2 chk("lit_byp_y0", y0, 4'h7); chk("lit_byp_v", y_valid, 4'b0101); chk("lit_byp_y2", y2, 4'h6);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_byp_v2", y_valid, 4'b0100);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_byp_empty", y_valid, 4'b0000);
    // load and drain on the same slot
    drive(1, 1, 4'h3, 4'b0000); #2 chk("lit_ld_ready", d_ready, 1);
    drive(1, 1, 4'h9, 4'b0010); #2 chk("lit_ld_y1", y1, 4'h3); chk("lit_ld_ready2", d_ready, 1);
    drive(0, 0, 4'h0, 4'b0000); #2 chk("lit_ld_v", y_valid, 4'b0010); chk("lit_ld_y1_new", y1, 4'h9);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_ld_v_still", y_valid, 4'b0010);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_ld_empty", y_valid, 4'b0000);
    // asynchronous reset with slots 1 and 3 full
    drive(1, 1, 4'h1, 4'b0000);
    drive(1, 3, 4'h8, 4'b0000);
    drive(0, 0, 4'h0, 4'b0000); #2 chk("lit_pre_rst_v", y_valid, 4'b1010); chk("lit_pre_rst_y3", y3, 4'h8);
    rst_n = 1'b0;
    #1 chk("lit_rst_v", y_valid, 4'b0000); chk("lit_rst_y1", y1, 0); chk("lit_rst_y3", y3, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2 chk("lit_rel_ready", d_ready, 1); chk("lit_rel_v", y_valid, 4'b0000);
    drive(0, 0, 4'h0, 4'hF); #2 chk("lit_rel_nodata", y_valid, 4'b0000);
    // random traffic; the upstream holds d/sel while stalled
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      hold = d_valid & ~d_ready;
      @(posedge clk);
      #1;
      if (!hold) begin
        d_valid = 1'($urandom_range(0, 1));
        sel = 2'($urandom_range(0, 3));
        d = 4'($urandom_range(0, 15));
      end
      y_ready = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    hold = d_valid & ~d_ready;
    if (hold) drive(1, sel, d, 4'hF);
    repeat (3) drive(0, 0, 4'h0, 4'hF);
    #2;
    left = 0;
    for (int i = 0; i < 4; i++) left += q[i].size();
    chk("rand_all_delivered", left, 0);
    chk("rand_final_valid", y_valid, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, data width of input and each output.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port d, input, WIDTH bits: input data word.
REQ-005 The block SHALL have port sel, input, 2 bits: destination index 0..3, sampled with d.
REQ-006 The block SHALL have port d_valid, input, 1 bit: d and sel valid this cycle.
REQ-007 The block SHALL have port d_ready, output, 1 bit: block accepts d this cycle.
REQ-008 The block SHALL have ports y0, y1, y2, y3, output, WIDTH bits each: per-destination data.
REQ-009 The block SHALL have port y_valid, output, 4 bits: bit i = yi holds an undelivered word.
REQ-010 The block SHALL have port y_ready, input, 4 bits: bit i = consumer i takes yi this cycle.

Function
REQ-011 Each destination i SHALL own a one-entry slot (data register plus full flag); y_valid[i] SHALL equal the full flag and yi SHALL equal the slot data register.
REQ-012 d_ready SHALL be combinational: 1 when slot[sel] is empty or y_ready[sel] is 1; it SHALL NOT depend on d_valid.
REQ-013 Accept = d_valid and d_ready; on accept, slot[sel] SHALL load d and set full at the next edge (latency 1 cycle, d to y_valid).
REQ-014 Drain on slot i = y_valid[i] and y_ready[i]; on drain without a load into slot i, full[i] SHALL clear at the next edge.
REQ-015 On simultaneous drain and load into the same slot, full SHALL stay 1 and the slot SHALL hold the new word; no bubble, no loss.
REQ-016 Loads and drains on different slots SHALL proceed independently in the same cycle; at most one load per cycle across all slots.
REQ-017 A full slot not drained SHALL hold its data and keep y_valid set, whatever d, sel or d_valid do (no overwrite).
REQ-018 An output whose slot is empty SHALL keep its last data value; consumers qualify data with y_valid only.
REQ-019 While d_valid=1 and d_ready=0 the block SHALL NOT accept, and the upstream holds d/sel stable by protocol.
REQ-020 Sustained throughput SHALL be one word per cycle when the consumer at sel keeps y_ready=1.

Reset
REQ-021 While rst_n=0, all full flags SHALL be 0 (y_valid=4'b0000) and y0..y3 SHALL be 0, asynchronously.
REQ-022 d_ready after reset SHALL be 1 (all slots empty); first accept possible on the first edge with rst_n=1.
REQ-023 Reset asserted mid-transfer SHALL discard all buffered words; no word SHALL reappear after reset release.

Structure
REQ-024 A package demux_pkg SHALL hold N_OUT=4 and the destination-index type (2-bit), shared with the mux blocks.
REQ-025 The per-destination slot SHALL be a sub-module demux_out_slot (ports: clk, rst_n, load, din, ready, valid, dout), instantiated four times.
REQ-026 The top level SHALL contain only the sel decode, d_ready selection and slot instances; expected size 120-250 lines total.

Verification
REQ-027 Reset: drive rst_n=0 mid-run with slots 1 and 3 full -> y_valid=0000, y0..y3=0 immediately; d_ready=1 after release.
REQ-028 Routing: y_ready=1111; send d=a,b,c,d with sel=0,1,2,3 back-to-back -> y0=a, y1=b, y2=c, y3=d each one cycle after accept; y_valid one-hot per cycle.
REQ-029 Backpressure: y_ready[2]=0, send 5 to sel=2 then 6 to sel=2 -> y2=5 held, d_ready=0 for second word until y_ready[2]=1; then 6 delivered next cycle.
REQ-030 Bypass while blocked: slot 2 full and stalled, send 7 to sel=0 -> d_ready=1, y0=7 next cycle; y2 unchanged.
REQ-031 Load+drain same slot: slot 1 holds 3, y_ready[1]=1, accept 9 to sel=1 same cycle -> y_valid[1] stays 1, y1=9 next cycle.
REQ-032 Random: 1000 cycles random d_valid/y_ready/sel, scoreboard per destination -> per-output order preserved, no loss, no duplicates.
